// File: rtl/led_dimmer_pkg.sv
// rtl/led_dimmer_pkg.sv - shared constants and the on-count to brightness map for led_dimmer
package led_dimmer_pkg;

  localparam int DEF_WIN_BITS   = 16;
  localparam int DEF_LEVEL_BITS = 8;
  localparam int DEF_MIN_LEVEL  = 8;

  function automatic int unsigned level_max(input int unsigned level_bits);
    return (32'd1 << level_bits) - 32'd1;
  endfunction

  function automatic int unsigned win_full(input int unsigned win_bits);
    return 32'd1 << win_bits;
  endfunction

  localparam int unsigned LEVEL_MAX = level_max(DEF_LEVEL_BITS);
  localparam int unsigned WIN_FULL  = win_full(DEF_WIN_BITS);

  // A completely full window saturates; any other nonzero count is floored so it stays visible.
  function automatic int unsigned level_map(input int unsigned n,
                                            input int unsigned win_bits,
                                            input int unsigned level_bits,
                                            input int unsigned min_level);
    int unsigned l;
    if (n == 32'd0) return 32'd0;
    if (n == win_full(win_bits)) return level_max(level_bits);
    l = n >> (win_bits - level_bits);
    return (l < min_level) ? min_level : l;
  endfunction

endpackage

// File: rtl/led_dimmer_channel.sv
// rtl/led_dimmer_channel.sv - one LED: window duty counter, latched level and PWM drive
module led_dimmer_channel
  import led_dimmer_pkg::*;
#(
  parameter int WIN_BITS   = DEF_WIN_BITS,
  parameter int LEVEL_BITS = DEF_LEVEL_BITS,
  parameter int MIN_LEVEL  = DEF_MIN_LEVEL
) (
  input  logic                  clock_160,
  input  logic                  res,
  input  logic                  led_bit,
  input  logic                  win_end,
  input  logic [LEVEL_BITS-1:0] pwm_cnt,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  led_out
);

  // One extra bit so a window that is high on every cycle still fits.
  logic [WIN_BITS:0] on_cnt;
  logic [WIN_BITS:0] n;

  always_comb begin
    n = on_cnt + {{WIN_BITS{1'b0}}, led_bit};
  end

  always_ff @(posedge clock_160 or posedge res) begin
    if (res) begin
      on_cnt  <= '0;
      level   <= '0;
      led_out <= 1'b0;
    end else begin
      if (win_end) begin
        on_cnt <= '0;
        level  <= LEVEL_BITS'(level_map(32'(n), WIN_BITS, LEVEL_BITS, MIN_LEVEL));
      end else begin
        on_cnt <= n;
      end
      led_out <= (level == '1) || (pwm_cnt < level);
    end
  end

endmodule

// File: rtl/led_dimmer.sv
// rtl/led_dimmer.sv - per-cog LED activity to steady PWM brightness, shared window and PWM timebase
module led_dimmer
  import led_dimmer_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int WIN_BITS   = DEF_WIN_BITS,
  parameter int LEVEL_BITS = DEF_LEVEL_BITS,
  parameter int MIN_LEVEL  = DEF_MIN_LEVEL
) (
  input  logic                           clock_160,
  input  logic                           res,
  input  logic [NUM_LEDS-1:0]            led_in,
  output logic [NUM_LEDS-1:0]            led_out,
  output logic [NUM_LEDS*LEVEL_BITS-1:0] level,
  output logic                           window_strobe
);

  logic [NUM_LEDS-1:0]   led_q;
  logic [WIN_BITS-1:0]   win_cnt;
  logic [LEVEL_BITS-1:0] pwm_cnt;
  logic                  win_end;

  assign win_end = (win_cnt == '1);

  // Window and PWM counters are deliberately unrelated; level changes land mid-period.
  always_ff @(posedge clock_160 or posedge res) begin
    if (res) begin
      led_q         <= '0;
      win_cnt       <= '0;
      pwm_cnt       <= '0;
      window_strobe <= 1'b0;
    end else begin
      led_q         <= led_in;
      win_cnt       <= win_cnt + WIN_BITS'(1);
      pwm_cnt       <= pwm_cnt + LEVEL_BITS'(1);
      window_strobe <= win_end;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    led_dimmer_channel #(
      .WIN_BITS  (WIN_BITS),
      .LEVEL_BITS(LEVEL_BITS),
      .MIN_LEVEL (MIN_LEVEL)
    ) u_chan (
      .clock_160(clock_160),
      .res      (res),
      .led_bit  (led_q[i]),
      .win_end  (win_end),
      .pwm_cnt  (pwm_cnt),
      .level    (level[i*LEVEL_BITS +: LEVEL_BITS]),
      .led_out  (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_dimmer.sv
// tb/tb_led_dimmer.sv - self-checking bench for led_dimmer with a window-sum reference model
module tb_led_dimmer;

  localparam int NL  = 8;
  localparam int WB  = 8;
  localparam int LB  = 4;
  localparam int ML  = 2;
  localparam int WIN = 256;
  localparam int PER = 16;

  logic              clock_160 = 1'b0;
  logic              res = 1'b0;
  logic [NL-1:0]     led_in = '0;
  logic [NL-1:0]     led_out;
  logic [NL*LB-1:0]  level;
  logic              window_strobe;

  int checks = 0;
  int errors = 0;

  logic all_on = 1'b1;
  logic ch4_on = 1'b1;

  always #5 clock_160 = ~clock_160;

  led_dimmer #(.NUM_LEDS(NL), .WIN_BITS(WB), .LEVEL_BITS(LB), .MIN_LEVEL(ML)) dut (
    .clock_160    (clock_160),
    .res          (res),
    .led_in       (led_in),
    .led_out      (led_out),
    .level        (level),
    .window_strobe(window_strobe)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int fmap(input int n);
    int l;
    if (n == 0) return 0;
    if (n == WIN) return PER - 1;
    l = n / (WIN / PER);
    return (l < ML) ? ML : l;
  endfunction

  // Model: edge count since reset, per-window sums of sampled led_in, latched levels.
  int          e = 0;
  int          acc[NL] = '{default: 0};
  int          lvl[NL] = '{default: 0};
  logic [NL-1:0] m_led = '0;
  logic        m_strobe = 1'b0;

  always @(posedge clock_160 or posedge res) begin
    if (res) begin
      e = 0;
      m_led = '0;
      m_strobe = 1'b0;
      for (int i = 0; i < NL; i++) begin
        acc[i] = 0;
        lvl[i] = 0;
      end
    end else begin
      e++;
      for (int i = 0; i < NL; i++)
        m_led[i] = (lvl[i] == PER - 1) || (((e - 1) % PER) < lvl[i]);
      m_strobe = (e % WIN == 0);
      for (int i = 0; i < NL; i++) begin
        if (m_strobe) begin
          lvl[i] = fmap(acc[i]);
          acc[i] = 0;
        end
        acc[i] += int'(led_in[i]);
      end
    end
  end

  always @(negedge clock_160) begin
    check("led_out", led_out, m_led);
    check("window_strobe", window_strobe, m_strobe);
    for (int i = 0; i < NL; i++)
      check("level", level[i*LB +: LB], lvl[i]);
  end

  function automatic logic [NL-1:0] pat(input int ee);
    int w;
    logic [NL-1:0] p;
    w = ee % WIN;
    p[0] = 1'b1;
    p[1] = (w < 128);
    p[2] = (w == 50);
    p[3] = 1'b0;
    p[4] = ch4_on;
    p[5] = 1'($urandom_range(0, 1));
    p[6] = (w < 16);
    p[7] = (w < 48);
    if (all_on) p = '1;
    return p;
  endfunction

  task automatic step();
    @(negedge clock_160);
    led_in = pat(e);
  endtask

  task automatic wait_strobe(output int cyc);
    cyc = 0;
    forever begin
      step();
      cyc++;
      if (window_strobe || cyc >= 600) break;
    end
    check("strobe_seen", window_strobe, 1);
  endtask

  task automatic step_until_phase(input int ph);
    int n;
    n = 0;
    while ((e % WIN) != ph && n < 600) begin
      step();
      n++;
    end
    check("phase_reached", e % WIN, ph);
  endtask

  int cyc;
  int hi[4];

  initial begin
    #1 res = 1'b1;
    all_on = 1'b1;
    led_in = '1;
    repeat (8) begin
      @(negedge clock_160);
      check("rst_led_out", led_out, 0);
      check("rst_level", level, 0);
      check("rst_strobe", window_strobe, 0);
    end

    #2 res = 1'b0;
    all_on = 1'b0;
    led_in = pat(e);
    wait_strobe(cyc);
    check("first_strobe_gap", cyc, 256);
    check("lvl0_full", level[0 +: LB], 15);
    check("lvl1_half", level[4 +: LB], 8);
    check("lvl2_floor", level[8 +: LB], 2);
    check("lvl3_dark", level[12 +: LB], 0);
    check("lvl4_first_win", level[16 +: LB], 15);
    check("lvl6_floor_edge", level[24 +: LB], 2);
    check("lvl7_above_floor", level[28 +: LB], 3);

    hi = '{default: 0};
    repeat (PER) begin
      step();
      for (int i = 0; i < 4; i++) hi[i] += int'(led_out[i]);
    end
    check("duty_ch0", hi[0], 16);
    check("duty_ch1", hi[1], 8);
    check("duty_ch2", hi[2], 2);
    check("duty_ch3", hi[3], 0);

    wait_strobe(cyc);
    check("strobe_period", cyc, 256 - PER);
    check("lvl1_half_w2", level[4 +: LB], 8);

    step_until_phase(254);
    ch4_on = 1'b0;
    step();
    wait_strobe(cyc);
    check("lvl4_before_dark", level[16 +: LB], 15);
    wait_strobe(cyc);
    check("strobe_period2", cyc, 256);
    check("lvl4_dark", level[16 +: LB], 0);
    step();
    check("led4_off", led_out[4], 0);

    all_on = 1'b1;
    step_until_phase(100);
    #2 res = 1'b1;
    #1;
    check("async_led_out", led_out, 0);
    check("async_level", level, 0);
    check("async_strobe", window_strobe, 0);
    repeat (3) @(negedge clock_160);
    #2 res = 1'b0;
    led_in = '1;
    wait_strobe(cyc);
    check("post_reset_gap", cyc, 256);
    check("post_reset_level", level, 32'hFFFF_FFFF);
    step();
    check("post_reset_led", led_out, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_dimmer.md
Name: led_dimmer

Overview:
- Sits directly downstream of the p1v core's 8-bit per-cog LED activity output (ledg), between the core and the board LED pins.
- Cog activity toggles at clock rate, so raw LEDs show near-constant glow. This block measures each LED's duty cycle over a fixed window and re-drives the LED with a steady PWM brightness.
- Guarantees a minimum visible level for any nonzero activity.
- Runs entirely in the clock_160 domain. The input needs no synchroniser.

Parameters:
- NUM_LEDS, 8, number of independent LED channels.
- WIN_BITS, 16, measurement window is 2^WIN_BITS cycles. Must be >= LEVEL_BITS.
- LEVEL_BITS, 8, brightness resolution. PWM period is 2^LEVEL_BITS cycles.
- MIN_LEVEL, 8, floor applied to any window with nonzero on-count. Must be < 2^LEVEL_BITS.

Ports:
- clock_160, input, 1, system clock.
- res, input, 1, reset.
- led_in, input, NUM_LEDS, raw activity bits from the core.
- led_out, output, NUM_LEDS, PWM-dimmed LED drive.
- level, output, NUM_LEDS*LEVEL_BITS, latched brightness per channel; channel i occupies bits [i*LEVEL_BITS +: LEVEL_BITS].
- window_strobe, output, 1, one-cycle pulse when level updates.

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (res=1, asynchronous):
  - led_q, win_cnt, pwm_cnt, every on_cnt and level are 0.
  - led_out and window_strobe are 0.
  - Takes effect immediately, including mid-window. After release, all counting restarts from 0 and any partial window is discarded.
- Input register: led_q <= led_in every cycle. Counting uses led_q, so there is one cycle of input latency.
- win_cnt (WIN_BITS wide):
  - Increments every cycle and wraps from all-ones to 0.
  - The end cycle E is the cycle in which win_cnt == all-ones.
- on_cnt[i] (WIN_BITS+1 wide, so a full window of 2^WIN_BITS cannot overflow):
  - Non-end cycle: on_cnt[i] <= on_cnt[i] + led_q[i].
  - End cycle: n = on_cnt[i] + led_q[i] is evaluated. on_cnt[i] <= 0, and level[i] <= f(n).
- f(n), in priority order:
  - n == 0 -> 0.
  - n == 2^WIN_BITS -> 2^LEVEL_BITS-1 (saturate).
  - otherwise l = n >> (WIN_BITS-LEVEL_BITS); result is max(l, MIN_LEVEL).
- window_strobe: registered, high for exactly one cycle, the cycle after E. It coincides with the first cycle the new level is visible. Period is exactly 2^WIN_BITS cycles.
- pwm_cnt (LEVEL_BITS wide): free-running, independent of win_cnt.
- led_out[i], registered:
  - level[i] == 2^LEVEL_BITS-1 -> 1 (constant on).
  - otherwise (pwm_cnt < level[i]).
  - level 0 -> constant off. Level L -> high L of every 2^LEVEL_BITS cycles.
  - A level change takes effect on the next compare; no resynchronisation to the PWM period.
- Channels are fully independent. Simultaneous activity on all channels needs no arbitration.
- First window after reset: led_q is 0 in its first cycle, so the maximum count is 2^WIN_BITS-1. f still yields top level when LEVEL_BITS < WIN_BITS, because of the shift.

Decomposition:
- Package led_dimmer_pkg:
  - function f (level_map), parameterised by widths.
  - localparams LEVEL_MAX and WIN_FULL.
- Sub-module led_dimmer_channel, instantiated per channel with a generate loop:
  - contains on_cnt, level register, level_map, PWM compare and led_out register.
  - takes led_q[i], the end-cycle flag and pwm_cnt.
- Top block owns led_q, win_cnt, pwm_cnt and window_strobe.

Test Plan (WIN_BITS=8, LEVEL_BITS=4, MIN_LEVEL=2):
- Reset and strobe:
  - Hold res=1 with led_in=8'hFF -> led_out=0, level=0, window_strobe=0 throughout.
  - Release res -> window_strobe pulses one cycle every 256 cycles; first pulse at cycle 256 after release.
- Full on: led_in[0]=1 constantly -> level[0]=15 after each strobe; led_out[0] constant 1.
- Half duty: led_in[1] high for win_cnt 0..127 of each window (one-cycle offset for led_q) -> level[1]=8; led_out[1] high 8 of every 16 cycles.
- Sparse activity and floor:
  - led_in[2] pulses one cycle per window -> n=1 -> level[2]=2 (floor); led_out[2] high 2/16.
  - Dark channel: led_in[3]=0 -> level[3]=0; led_out[3] never high.
- Mid-window reset: led_in=8'hFF, assert res at win_cnt=100 for 3 cycles -> led_out=0 and level=0 asynchronously. Next strobe is 256 cycles after release, with level=15 on all channels.
- Level transition: switch led_in[4] from always-on to always-off -> level[4] goes 15 to 0 exactly at the strobe after the first all-zero window; led_out[4] is 0 from the next cycle.
